// File: rtl/seq_tx_pkg.sv
// Shared definitions for the serial stream transmitter: FSM state encoding
// and the default parameter set.
package seq_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_BIT_DIV = 1;
  localparam int unsigned DEF_GAP     = 2;

endpackage

// File: rtl/seq_tx_bit_timer.sv
// Bit-time divider: pulses bit_end on the last clk cycle of every BIT_DIV-cycle
// bit period; clear restarts the period from its first cycle.
module seq_tx_bit_timer
  import seq_tx_pkg::*;
#(
  parameter int unsigned BIT_DIV = DEF_BIT_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;

  assign bit_end = (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q + 1'b1;
    if (clear || bit_end) begin
      div_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/seq_stream_tx.sv
// Serial transmitter: accepts parallel words on a valid/ready handshake and
// shifts them out MSB-first, with a programmable bit time and idle gap.
module seq_stream_tx
  import seq_tx_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned BIT_DIV = DEF_BIT_DIV,
  parameter int unsigned GAP     = DEF_GAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam int unsigned BIT_W   = $clog2(WIDTH);
  localparam int unsigned GAP_CYC = GAP * BIT_DIV;
  localparam int unsigned GAP_W   = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;
  logic               last_bit_q, last_bit_d;
  logic               bit_end;
  logic               timer_clear;

  // The divider only runs inside SHIFT and restarts on every state change.
  assign timer_clear = (state_q != ST_SHIFT) || (state_d != state_q);

  seq_tx_bit_timer #(
    .BIT_DIV (BIT_DIV)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d   = ST_SHIFT;
          shreg_d   = in_data;
          bit_cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        if (bit_end) begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            gap_cnt_d = '0;
            state_d   = (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Serial outputs are registered from the next-state view so they line up
    // with the state they describe.
    dout_valid_d = (state_d == ST_SHIFT);
    dout_d       = (state_d == ST_SHIFT) && shreg_d[WIDTH-1];
    last_bit_d   = (state_d == ST_SHIFT) && (bit_cnt_d == BIT_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      last_bit_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      last_bit_q   <= last_bit_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q == ST_SHIFT) || (state_q == ST_GAP);
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign last_bit   = last_bit_q;

endmodule
